program_loader: RTL and testbench

Writes a program image into the picoMIPS program memory from a byte stream, holding the CPU in reset until the image is complete. It is the write-side counterpart of the program memory's read port, which the CPU fetch path uses. It accepts bytes over a valid/ready handshake and assembles them high byte first into 16-bit instruction words. It writes each word to consecutive addresses starting at 0, then releases the CPU.

---
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream loader for the picoMIPS program memory; keeps the CPU in reset until the image is written.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    load_len,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;
  localparam state_t S_FIN = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_DONE, S_ERROR
  } state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  state_t          state;
  state_t          nxt;
  logic [ADDR_W:0] cnt;
  logic            accept;

  // byte_ready is a registered copy of the state decode, so this is state-qualified
  assign accept = byte_valid && byte_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;

  assign csum_ok = (byte_data == csum);
`else
  assign error = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          nxt = (load_len == '0) ? S_FIN : S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          nxt = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        nxt = (cnt == (ADDR_W+1)'(1)) ? S_FIN : S_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          nxt = csum_ok ? S_DONE : S_ERROR;
        end
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      error      <= 1'b0;
      csum       <= '0;
`endif
    end else begin
      state      <= nxt;
`ifdef LOADER_CHECKSUM_EN
      byte_ready <= (nxt == S_HI) || (nxt == S_LO) || (nxt == S_CHECK);
      error      <= (nxt == S_ERROR);
`else
      byte_ready <= (nxt == S_HI) || (nxt == S_LO);
`endif
      wr_en      <= (nxt == S_WRITE);
      done       <= (nxt == S_DONE);
      cpu_hold   <= (nxt != S_DONE);

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            cnt     <= load_len;
            wr_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        S_HI: begin
          if (accept) begin
            wr_data[INSTR_W-1 -: 8] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        S_LO: begin
          if (accept) begin
            wr_data[7:0] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
          end
        end
        S_WRITE: begin
          // After the final word the address may wrap to 0, but no write follows
          wr_addr <= wr_addr + ADDR_W'(1);
          cnt     <= cnt - (ADDR_W+1)'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; also covers the checksum build when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef logic [7:0] bq_t[$];

  logic               clk;
  logic               reset;
  logic               start;
  logic [ADDR_W:0]    load_len;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               cpu_hold;
  logic               done;
  logic               error;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0]  wq_addr[$];
  logic [INSTR_W-1:0] wq_data[$];
  int                 wq_cyc[$];
  int                 cyc_ctr = 0;

  program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write cycle seen by the memory
  always @(negedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (!reset && wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc_ctr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int k);
    return (k < wq_addr.size()) ? 32'(wq_addr[k]) : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wd(input int k);
    return (k < wq_data.size()) ? 32'(wq_data[k]) : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wc(input int k);
    return (k < wq_cyc.size()) ? 32'(wq_cyc[k]) : 32'hxxxxxxxx;
  endfunction

  function automatic bq_t with_csum(input bq_t q);
    bq_t        r = q;
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    if (CS != 0) r.push_back(x);
    return r;
  endfunction

  // Issue start, stream bytes with optional stall/ignored start/reset, return negedges until done/error
  task automatic run_load(input int len, input bq_t b, input int stall_at, input int stall_n,
                          input int rs_cyc, input int rst_cyc, output int cyc_done);
    int   idx     = 0;
    int   stalled = 0;
    int   cyc     = 0;
    logic rdy_q;
    cyc_done = -1;
    @(negedge clk);
    load_len   = (ADDR_W+1)'(len);
    start      = 1'b1;
    byte_valid = (b.size() > 0);
    byte_data  = (b.size() > 0) ? b[0] : 8'h00;
    rdy_q      = byte_ready;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rdy_q && byte_valid) idx++;
      if (cyc == 1 && len > 0) check("start_raises_hold", {29'd0, cpu_hold, done, error}, 32'h4);
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_hold_done", {30'd0, cpu_hold, done}, 32'h2);
        check("rst_idle_ready", byte_ready, 0);
        check("rst_addr", wr_addr, 0);
        byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (done || error) begin
        cyc_done = cyc;
        break;
      end
      if (cyc == rs_cyc) begin
        start    = 1'b1;
        load_len = 7'd5;
      end
      if (cyc == rs_cyc + 1) check("ign_start_addr", {26'd0, wr_addr}, 32'd1);
      if (idx == stall_at && stalled < stall_n) begin
        byte_valid = 1'b0;
        stalled++;
        check("stall_in_lo", {30'd0, byte_ready, wr_en}, 32'h2);
      end else begin
        byte_valid = (idx < b.size());
        byte_data  = (idx < b.size()) ? b[idx] : 8'h00;
      end
      rdy_q = byte_ready;
    end
    byte_valid = 1'b0;
    if (cyc_done < 0) check("load_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t q;
    int  cd;
    int  base;

    reset      = 1'b1;
    start      = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {27'd0, wr_en, byte_ready, cpu_hold, done, error}, 32'h04);
    check("reset_addr", wr_addr, 0);
    check("reset_data", wr_data, 0);
    reset = 1'b0;

    // Basic three-word load
    base = wq_addr.size();
    q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    run_load(3, with_csum(q), -1, 0, -1, -1, cd);
    check("basic_cycles", cd, 3*3 + 1 + CS);
    check("basic_nwr", wq_addr.size() - base, 3);
    check("basic_a0", wa(base),     0); check("basic_d0", wd(base),     16'h1234);
    check("basic_a1", wa(base + 1), 1); check("basic_d1", wd(base + 1), 16'hABCD);
    check("basic_a2", wa(base + 2), 2); check("basic_d2", wd(base + 2), 16'h00FF);
    check("basic_gap1", wc(base + 1) - wc(base), 3);
    check("basic_gap2", wc(base + 2) - wc(base + 1), 3);
    check("basic_done", {30'd0, cpu_hold, done}, 32'h1);

    // Stall between the two bytes of word 0 (restarts from DONE)
    base = wq_addr.size();
    q = '{8'hA5, 8'h5A};
    run_load(1, with_csum(q), 1, 5, -1, -1, cd);
    check("stall_cycles", cd, 3 + 1 + 5 + CS);
    check("stall_nwr", wq_addr.size() - base, 1);
    check("stall_a0", wa(base), 0);
    check("stall_d0", wd(base), 16'hA55A);

    // Start pulse while in HI of word 1 is ignored
    base = wq_addr.size();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(2, with_csum(q), -1, 0, 4, -1, cd);
    check("ign_cycles", cd, 3*2 + 1 + CS);
    check("ign_nwr", wq_addr.size() - base, 2);
    check("ign_a1", wa(base + 1), 1);
    check("ign_d1", wd(base + 1), 16'h3344);

    // Zero-length load
    base = wq_addr.size();
    q = {};
    run_load(0, with_csum(q), -1, 0, -1, -1, cd);
    check("zero_cycles", cd, 1 + CS);
    check("zero_nwr", wq_addr.size() - base, 0);
    check("zero_done", {30'd0, cpu_hold, done}, 32'h1);

    // Full depth: word i = {i, C0^i}
    base = wq_addr.size();
    q = {};
    for (int i = 0; i < 64; i++) begin
      q.push_back(8'(i));
      q.push_back(8'hC0 ^ 8'(i));
    end
    run_load(64, with_csum(q), -1, 0, -1, -1, cd);
    check("full_cycles", cd, 3*64 + 1 + CS);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("full_a%0d", i), wa(base + i), i);
      check($sformatf("full_d%0d", i), wd(base + i), {8'(i), 8'hC0 ^ 8'(i)});
    end
    repeat (4) @(negedge clk);
    check("full_no_wrap_write", wq_addr.size() - base, 64);
    check("full_done", done, 1);

    // Reset during LO of the second word, then a clean one-word load
    base = wq_addr.size();
    q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    run_load(3, with_csum(q), -1, 0, -1, 5, cd);
    check("rst_kept_nwr", wq_addr.size() - base, 1);
    check("rst_kept_d0", wd(base), 16'h1234);
    base = wq_addr.size();
    q = '{8'hBE, 8'hEF};
    run_load(1, with_csum(q), -1, 0, -1, -1, cd);
    check("after_rst_cycles", cd, 3 + 1 + CS);
    check("after_rst_d0", wd(base), 16'hBEEF);
    check("after_rst_done", {30'd0, cpu_hold, done}, 32'h1);

`ifdef LOADER_CHECKSUM_EN
    q = '{8'h12, 8'h34, 8'h26};
    run_load(1, q, -1, 0, -1, -1, cd);
    check("csum_good", {29'd0, cpu_hold, done, error}, 32'h2);
    q = '{8'h12, 8'h34, 8'h27};
    run_load(1, q, -1, 0, -1, -1, cd);
    check("csum_bad_cycles", cd, 5);
    check("csum_bad", {29'd0, cpu_hold, done, error}, 32'h5);
    q = '{8'h12, 8'h34};
    run_load(1, with_csum(q), -1, 0, -1, -1, cd);
    check("csum_recover", {29'd0, cpu_hold, done, error}, 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
